// File: rtl/nibalu_pkg.sv
// Shared opcodes and sequencer state encoding for the nibble-serial ALU sequencer.
package nibalu_pkg;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_NEG = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Carry injected into nibble 0: NEG and SUB need the +1 of two's complement.
    function automatic logic first_carry(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/nibalu_flags.sv
// Combinational zero/negative/overflow flags from an assembled result word,
// the opcode and the operand sign information captured at accept time.
module nibalu_flags
    import nibalu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] y,
    input  logic [1:0]   op,
    input  logic         a_msb,
    input  logic         b_msb,
    input  logic         b_min,
    output logic         z,
    output logic         n,
    output logic         v
);

    logic y_msb;

    assign y_msb = y[W-1];
    assign z     = (y == '0);
    assign n     = y_msb;

    always_comb begin
        v = 1'b0;
        case (op)
            OP_ADD:  v = (a_msb == b_msb) && (y_msb != a_msb);
            OP_SUB:  v = (a_msb != b_msb) && (y_msb != a_msb);
            OP_NEG:  v = b_min;
            default: v = 1'b0;
        endcase
    end

endmodule

// File: rtl/nibble_alu_seq.sv
// Nibble-serial sequencer driving an external 4-bit add/sub/move/negate slice.
// Optional flag logic (out_z/out_n/out_v) is built only when NIBALU_FLAGS_EN is defined.
module nibble_alu_seq
    import nibalu_pkg::*;
#(
    parameter  int NIB = 4,
    localparam int W   = 4 * NIB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_y,
    output logic         out_c,
    output logic         out_z,
    output logic         out_n,
    output logic         out_v,
    output logic         alu_sub,
    output logic         alu_ena,
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    output logic         alu_ci,
    input  logic [3:0]   alu_y,
    input  logic         alu_co
);

    localparam int CW = $clog2(NIB + 1);

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   r_q, r_d;
    logic [1:0]     op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_y_q, out_y_d;
    logic           out_c_q, out_c_d;

    logic           run;
    logic           last_nib;
    logic           accept;
    logic           load_out;

    assign run      = (state_q == S_RUN);
    assign last_nib = (cnt_q == CW'(NIB - 1));
    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_ready && in_valid;
    // First DONE cycle registers the finished word and flags; out_valid follows.
    assign load_out = (state_q == S_DONE) && !out_valid_q;

    assign alu_a   = run ? a_q[3:0] : 4'h0;
    assign alu_b   = run ? b_q[3:0] : 4'h0;
    assign alu_sub = run && op_q[0];
    assign alu_ena = run && op_q[1];
    assign alu_ci  = run && ((cnt_q == '0) ? first_carry(op_q) : carry_q);

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_c     = out_c_q;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_c_d     = out_c_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    op_d    = in_op;
                    r_d     = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                r_d     = {alu_y, r_q[W-1:4]};
                carry_d = alu_co;
                a_d     = {4'h0, a_q[W-1:4]};
                b_d     = {4'h0, b_q[W-1:4]};
                cnt_d   = cnt_q + CW'(1);
                if (last_nib) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (load_out) begin
                    out_valid_d = 1'b1;
                    out_y_d     = r_q;
                    out_c_d     = carry_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            op_q        <= OP_MOV;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_c_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_c_q     <= out_c_d;
        end
    end

`ifdef NIBALU_FLAGS_EN
    logic       a_msb_q, a_msb_d;
    logic       b_msb_q, b_msb_d;
    logic       b_min_q, b_min_d;
    logic [2:0] flags_q, flags_d;
    logic       flag_z, flag_n, flag_v;

    // Original sign bits are lost as the operands shift, so keep them from accept.
    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        b_min_d = b_min_q;
        flags_d = flags_q;
        if (accept) begin
            a_msb_d = in_a[W-1];
            b_msb_d = in_b[W-1];
            b_min_d = (in_b == (W'(1) << (W - 1)));
        end
        if (load_out) begin
            flags_d = {flag_z, flag_n, flag_v};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            b_min_q <= 1'b0;
            flags_q <= 3'b000;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            b_min_q <= b_min_d;
            flags_q <= flags_d;
        end
    end

    nibalu_flags #(
        .W (W)
    ) u_flags (
        .y     (r_q),
        .op    (op_q),
        .a_msb (a_msb_q),
        .b_msb (b_msb_q),
        .b_min (b_min_q),
        .z     (flag_z),
        .n     (flag_n),
        .v     (flag_v)
    );

    assign out_z = flags_q[2];
    assign out_n = flags_q[1];
    assign out_v = flags_q[0];
`else
    assign out_z = 1'b0;
    assign out_n = 1'b0;
    assign out_v = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_alu_seq.sv
// Randomised and directed bench for nibble_alu_seq (NIB=4) with a behavioural slice
// and a word-level arithmetic reference model.
module tb_nibble_alu_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_a, in_b;
    logic         out_valid, out_ready;
    logic [W-1:0] out_y;
    logic         out_c, out_z, out_n, out_v;
    logic         alu_sub, alu_ena, alu_ci, alu_co;
    logic [3:0]   alu_a, alu_b, alu_y;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural 4-bit slice: Y = (ENA ? A : 0) + (SUB ? ~B : B) + CI.
    always_comb begin
        logic [4:0] s;
        s = {1'b0, (alu_ena ? alu_a : 4'h0)} + {1'b0, (alu_sub ? ~alu_b : alu_b)} + {4'h0, alu_ci};
        alu_y  = s[3:0];
        alu_co = s[4];
    end

    nibble_alu_seq #(.NIB(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_c     (out_c),
        .out_z     (out_z),
        .out_n     (out_n),
        .out_v     (out_v),
        .alu_sub   (alu_sub),
        .alu_ena   (alu_ena),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ci    (alu_ci),
        .alu_y     (alu_y),
        .alu_co    (alu_co)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int to_signed(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    // Word-level reference: result, carry and flags straight from the arithmetic rules.
    task automatic model(input logic [1:0] op, input int a, input int b,
                         output int y, output int c, output int z, output int n, output int v);
        int r;
        case (op)
            2'b00: begin y = b; c = 0; v = 0; end
            2'b01: begin y = (65536 - b) & 16'hFFFF; c = (b == 0); v = (b == 16'h8000); end
            2'b10: begin
                y = (a + b) & 16'hFFFF; c = (a + b) >> 16;
                r = to_signed(a) + to_signed(b); v = (r > 32767 || r < -32768);
            end
            default: begin
                y = (a - b) & 16'hFFFF; c = (a >= b);
                r = to_signed(a) - to_signed(b); v = (r > 32767 || r < -32768);
            end
        endcase
        z = (y == 0);
        n = (y >> 15) & 1;
`ifndef NIBALU_FLAGS_EN
        z = 0; n = 0; v = 0;
`endif
    endtask

    // Carry expected into nibble i, from the partial sum of the low i nibbles.
    function automatic int exp_ci(input logic [1:0] op, input int a, input int b, input int i);
        int ap, bp, mask;
        if (i == 0) return op[0];
        ap   = op[1] ? a : 0;
        bp   = op[0] ? (~b & 16'hFFFF) : b;
        mask = (1 << (4 * i)) - 1;
        return (((ap & mask) + (bp & mask) + op[0]) >> (4 * i)) & 1;
    endfunction

    task automatic wait_ready();
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", in_ready, 1);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold);
        int ey, ec, ez, en, ev, lat;
        logic [W-1:0] y0;
        model(op, a, b, ey, ec, ez, en, ev);
        wait_ready();
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom); in_op = 2'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (lat < NIB) begin
                check("alu_ci", alu_ci, exp_ci(op, a, b, lat));
                check("alu_a", alu_a, (a >> (4 * lat)) & 4'hF);
                check("alu_b", alu_b, (b >> (4 * lat)) & 4'hF);
            end
            @(negedge clk);
            lat++;
        end
        check("latency", lat, NIB + 1);
        check("out_y", out_y, ey);
        check("out_c", out_c, ec);
        check("out_z", out_z, ez);
        check("out_n", out_n, en);
        check("out_v", out_v, ev);
        check("in_ready_done", in_ready, 0);
        $display("op=%0d a=0x%04h b=0x%04h -> y=0x%04h c=%0d z=%0d n=%0d v=%0d lat=%0d",
                 op, a, b, out_y, out_c, out_z, out_n, out_v, lat);
        y0 = out_y;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_y", out_y, y0);
            check("hold_flags", {out_c, out_z, out_n, out_v}, {ec[0], ez[0], en[0], ev[0]});
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    initial begin
        int saw_valid;
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, 0);
        check("rst_flags", {out_c, out_z, out_n, out_v}, 0);
        check("rst_alu", {alu_a, alu_b, alu_ci, alu_sub, alu_ena}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b10, 16'h1234, 16'h0FCD, 0);
        run_op(2'b11, 16'h0005, 16'h0007, 0);
        run_op(2'b01, 16'h0000, 16'h8000, 0);
        run_op(2'b01, 16'h0000, 16'h0000, 0);
        run_op(2'b00, 16'h0000, 16'hABCD, 0);
        run_op(2'b10, 16'hFFFF, 16'h0001, 0);
        run_op(2'b10, 16'h7FFF, 16'h0001, 10);
        run_op(2'b11, 16'h8000, 16'h0001, 0);

        // Reset during nibble 2 of a SUB discards the operation.
        wait_ready();
        in_valid = 1'b1; in_op = 2'b11; in_a = 16'h4321; in_b = 16'h1111;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_alu", {alu_a, alu_b, alu_ci, alu_sub, alu_ena}, 0);
        saw_valid = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) saw_valid = 1;
            @(negedge clk);
        end
        check("midrst_no_valid", saw_valid, 0);
        $display("mid-run reset: in_ready=%0d out_valid_seen=%0d", in_ready, saw_valid);
        run_op(2'b10, 16'h1234, 16'h0FCD, 0);

        for (int t = 0; t < 40; t++) begin
            logic [1:0]   op;
            logic [W-1:0] a, b;
            op = 2'($urandom);
            a  = W'($urandom);
            b  = W'($urandom);
            if ($urandom_range(0, 7) == 0) b = 16'h8000;
            if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(op, a, b, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
